// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl_pkg
// Brief   : Opcode/func constants, state codes and control-field encodings
//           shared by the multi-cycle MIPS controller.
// Revision: 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LUI   = 6'b001111;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  localparam logic [5:0] c_FN_NOP   = 6'b000000;
  localparam logic [5:0] c_FN_JR    = 6'b001000;
  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] c_PCSRC_PC4  = 2'b00;
  localparam logic [1:0] c_PCSRC_BR   = 2'b01;
  localparam logic [1:0] c_PCSRC_JIDX = 2'b10;
  localparam logic [1:0] c_PCSRC_JR   = 2'b11;

  localparam logic [1:0] c_REGDST_RT  = 2'b00;
  localparam logic [1:0] c_REGDST_RD  = 2'b01;
  localparam logic [1:0] c_REGDST_RA  = 2'b10;

  localparam logic [2:0] c_ALU_ADD    = 3'b000;
  localparam logic [2:0] c_ALU_SUB    = 3'b001;
  localparam logic [2:0] c_ALU_OR     = 3'b010;
  localparam logic [2:0] c_ALU_LUI    = 3'b011;

  localparam logic [1:0] c_EXT_ZERO   = 2'b00;
  localparam logic [1:0] c_EXT_SIGN   = 2'b01;
  localparam logic [1:0] c_EXT_HIGH   = 2'b10;

  localparam logic [1:0] c_DATA_ALU   = 2'b00;
  localparam logic [1:0] c_DATA_DM    = 2'b01;
  localparam logic [1:0] c_DATA_PC4   = 2'b10;

  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } iclass_t;

  // Classes that need the ALU cycle; everything else finishes in DECODE.
  function automatic logic needs_exec(input iclass_t c);
    return c.rtype_alu | c.ori | c.lui | c.lw | c.sw | c.beq;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_instr_class.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl_instr_class
// Brief   : Combinational op/func decode into a one-hot instruction class.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_ctrl_instr_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output iclass_t    o_class
);

  always_comb begin
    o_class = '0;
    case (i_op)
      c_OP_RTYPE: begin
        case (i_func)
          c_FN_ADDU, c_FN_SUBU: o_class.rtype_alu = 1'b1;
          c_FN_JR:              o_class.jr        = 1'b1;
          default:              o_class.nop       = 1'b1;
        endcase
      end
      c_OP_ORI: o_class.ori = 1'b1;
      c_OP_LUI: o_class.lui = 1'b1;
      c_OP_LW:  o_class.lw  = 1'b1;
      c_OP_SW:  o_class.sw  = 1'b1;
      c_OP_BEQ: o_class.beq = 1'b1;
      c_OP_J:   o_class.j   = 1'b1;
      c_OP_JAL: o_class.jal = 1'b1;
      // Unsupported opcodes retire as a no-op.
      default:  o_class.nop = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB).
//           Optional MEM wait/timeout handshake with MCTRL_MEM_WAIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       ZERO,
  input  logic       dmem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic [1:0] PCSrc,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [2:0] ALUop,
  output logic [1:0] EXTop,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic [1:0] Data,
  output logic       retire,
  output logic       mem_err,
  output logic [2:0] state
);

  state_t  r_state;
  state_t  w_next;
  iclass_t w_cls;
  logic    w_mem_done;
  logic    w_mem_abort;

  multicycle_ctrl_instr_class u_class (
    .i_op    (op),
    .i_func  (func),
    .o_class (w_cls)
  );

`ifdef MCTRL_MEM_WAIT_EN
  localparam int c_CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  logic [c_CNT_W-1:0] r_wait;

  // Counts unanswered MEM cycles; any cycle outside MEM clears it.
  always_ff @(posedge clk) begin
    if (!reset || (r_state != S_MEM)) begin
      r_wait <= '0;
    end else if (!dmem_ready && (WAIT_TIMEOUT > 0)) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign w_mem_done = dmem_ready;

  generate
    if (WAIT_TIMEOUT > 0) begin : g_timeout
      assign w_mem_abort = !dmem_ready && (r_wait == c_CNT_W'(WAIT_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_mem_abort = 1'b0;
    end
  endgenerate
`else
  logic w_unused_ok;

  assign w_mem_done  = 1'b1;
  assign w_mem_abort = 1'b0;
  assign w_unused_ok = dmem_ready ^ (WAIT_TIMEOUT == 0);
`endif

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = needs_exec(w_cls) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (w_cls.lw || w_cls.sw)                     w_next = S_MEM;
        else if (w_cls.rtype_alu || w_cls.ori || w_cls.lui) w_next = S_WB;
        else                                          w_next = S_FETCH;
      end
      S_MEM: begin
        if (w_mem_abort)      w_next = S_FETCH;
        else if (!w_mem_done) w_next = S_MEM;
        else if (w_cls.lw)    w_next = S_WB;
        else                  w_next = S_FETCH;
      end
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Everything is forced low while reset is held, including the debug state.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    PCSrc    = c_PCSRC_PC4;
    RegDst   = c_REGDST_RT;
    ALUSrc   = 1'b0;
    ALUop    = c_ALU_ADD;
    EXTop    = c_EXT_ZERO;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    Data     = c_DATA_ALU;
    retire   = 1'b0;
    mem_err  = 1'b0;
    state    = 3'd0;
    if (reset) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = c_PCSRC_PC4;
        end
        S_DECODE: begin
          if (w_cls.j || w_cls.jal) begin
            PCWrite = 1'b1;
            PCSrc   = c_PCSRC_JIDX;
            retire  = 1'b1;
            if (w_cls.jal) begin
              RegWrite = 1'b1;
              RegDst   = c_REGDST_RA;
              Data     = c_DATA_PC4;
            end
          end else if (w_cls.jr) begin
            PCWrite = 1'b1;
            PCSrc   = c_PCSRC_JR;
            retire  = 1'b1;
          end else if (w_cls.nop) begin
            retire  = 1'b1;
          end
        end
        S_EXEC: begin
          if (w_cls.rtype_alu) begin
            ALUop  = (func == c_FN_SUBU) ? c_ALU_SUB : c_ALU_ADD;
            ALUSrc = 1'b0;
          end else if (w_cls.ori) begin
            ALUop  = c_ALU_OR;
            EXTop  = c_EXT_ZERO;
            ALUSrc = 1'b1;
          end else if (w_cls.lui) begin
            ALUop  = c_ALU_LUI;
            EXTop  = c_EXT_HIGH;
            ALUSrc = 1'b1;
          end else if (w_cls.lw || w_cls.sw) begin
            ALUop  = c_ALU_ADD;
            EXTop  = c_EXT_SIGN;
            ALUSrc = 1'b1;
          end else if (w_cls.beq) begin
            ALUop   = c_ALU_SUB;
            PCSrc   = c_PCSRC_BR;
            PCWrite = ZERO;
            retire  = 1'b1;
          end
        end
        S_MEM: begin
          MemRead  = w_cls.lw;
          MemWrite = w_cls.sw;
          mem_err  = w_mem_abort;
          retire   = w_cls.sw && w_mem_done && !w_mem_abort;
        end
        S_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          if (w_cls.rtype_alu) begin
            RegDst = c_REGDST_RD;
            Data   = c_DATA_ALU;
          end else if (w_cls.lw) begin
            RegDst = c_REGDST_RT;
            Data   = c_DATA_DM;
          end else begin
            RegDst = c_REGDST_RT;
            Data   = c_DATA_ALU;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
